// File: rtl/e203_tb_irq_injector.sv
// Bench-side interrupt injector: arms on a commit PC, raises ext/sft/tmr IRQs after
// LFSR-derived delays, drops each on its handler commit, and stops after enough tohost writes.
module e203_tb_irq_injector #(
  parameter int unsigned          PC_SIZE    = 32,
  parameter logic [PC_SIZE-1:0]   PC_ARM     = 32'h8000015C,
  parameter logic [PC_SIZE-1:0]   PC_TOHOST  = 32'h80000086,
  parameter logic [PC_SIZE-1:0]   PC_EXT_HDL = 32'h800000A6,
  parameter logic [PC_SIZE-1:0]   PC_SFT_HDL = 32'h800000BE,
  parameter logic [PC_SIZE-1:0]   PC_TMR_HDL = 32'h800000D6,
  parameter int unsigned          MAX_GAP_W  = 10,
  parameter int unsigned          STOP_CNT   = 32,
  parameter logic [15:0]          SEED_EXT   = 16'hACE1,
  parameter logic [15:0]          SEED_SFT   = 16'h1D87,
  parameter logic [15:0]          SEED_TMR   = 16'h5A5A
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               cmt_valid,
  input  logic [PC_SIZE-1:0] cmt_pc,
  output logic               ext_irq,
  output logic               sft_irq,
  output logic               tmr_irq,
  output logic               armed,
  output logic               stopped,
  output logic               irq_quiet,
  output logic [31:0]        tohost_cnt,
  output logic [15:0]        ext_inj_cnt,
  output logic [15:0]        sft_inj_cnt,
  output logic [15:0]        tmr_inj_cnt
);

  localparam int unsigned CntW     = MAX_GAP_W + 1;
  localparam logic [15:0] LfsrTaps = 16'hB400;
  // An all-zero Galois LFSR would lock up, so a zero seed is nudged to 1.
  localparam logic [15:0] SeedExt  = (SEED_EXT == 16'h0) ? 16'h0001 : SEED_EXT;
  localparam logic [15:0] SeedSft  = (SEED_SFT == 16'h0) ? 16'h0001 : SEED_SFT;
  localparam logic [15:0] SeedTmr  = (SEED_TMR == 16'h0) ? 16'h0001 : SEED_TMR;

  typedef enum logic [1:0] {StIdle, StWait, StAssert, StDone} chan_state_e;

  logic                    hit_arm, hit_tohost, arm_evt;
  logic [2:0]              hdl_hit;
  logic                    armed_q, armed_d;
  logic                    stopped_q, stopped_d;
  logic [31:0]             tohost_cnt_q, tohost_cnt_d;
  logic [2:0]              irq_q, irq_d;
  logic [2:0][15:0]        lfsr_q, lfsr_d;
  logic [2:0][CntW-1:0]    cnt_q, cnt_d, delay;
  logic [2:0][15:0]        inj_cnt_q, inj_cnt_d;
  chan_state_e             state_q [3];
  chan_state_e             state_d [3];

  assign hit_arm    = cmt_valid & (cmt_pc == PC_ARM);
  assign hit_tohost = cmt_valid & (cmt_pc == PC_TOHOST);
  assign hdl_hit[0] = cmt_valid & (cmt_pc == PC_EXT_HDL);
  assign hdl_hit[1] = cmt_valid & (cmt_pc == PC_SFT_HDL);
  assign hdl_hit[2] = cmt_valid & (cmt_pc == PC_TMR_HDL);
  assign arm_evt    = hit_arm & enable & ~armed_q;

  always_comb begin
    armed_d      = armed_q | (hit_arm & enable);
    tohost_cnt_d = tohost_cnt_q;
    if (hit_tohost && (tohost_cnt_q != 32'hFFFF_FFFF)) begin
      tohost_cnt_d = tohost_cnt_q + 32'd1;
    end
    // Looking at the next count lets a same-cycle tohost hit stop a channel leaving ASSERT.
    stopped_d = stopped_q | (tohost_cnt_d > 32'(STOP_CNT));
  end

  always_comb begin
    lfsr_d    = lfsr_q;
    cnt_d     = cnt_q;
    delay     = '0;
    irq_d     = irq_q;
    inj_cnt_d = inj_cnt_q;
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      lfsr_d[i]  = {1'b0, lfsr_q[i][15:1]} ^ (lfsr_q[i][0] ? LfsrTaps : 16'h0000);
      delay[i]   = CntW'(lfsr_q[i][MAX_GAP_W-1:0]) + CntW'(1);
      unique case (state_q[i])
        StIdle: begin
          irq_d[i] = 1'b0;
          if (arm_evt || (armed_q && enable && !stopped_q)) begin
            state_d[i] = StWait;
            cnt_d[i]   = delay[i];
          end
        end
        StWait: begin
          irq_d[i] = 1'b0;
          if (stopped_q) begin
            state_d[i] = StDone;
          end else if (!enable) begin
            state_d[i] = StIdle;
          end else if (cnt_q[i] == CntW'(1)) begin
            state_d[i] = StAssert;
            irq_d[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - CntW'(1);
          end
        end
        StAssert: begin
          // Only the handler commit releases the line; enable is ignored while asserted.
          if (hdl_hit[i]) begin
            irq_d[i] = 1'b0;
            if (inj_cnt_q[i] != 16'hFFFF) inj_cnt_d[i] = inj_cnt_q[i] + 16'd1;
            if (stopped_d) begin
              state_d[i] = StDone;
            end else if (!enable) begin
              state_d[i] = StIdle;
            end else begin
              state_d[i] = StWait;
              cnt_d[i]   = delay[i];
            end
          end
        end
        StDone: irq_d[i] = 1'b0;
        default: begin
          state_d[i] = StIdle;
          irq_d[i]   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q      <= 1'b0;
      stopped_q    <= 1'b0;
      tohost_cnt_q <= '0;
      irq_q        <= '0;
      cnt_q        <= '0;
      inj_cnt_q    <= '0;
      lfsr_q[0]    <= SeedExt;
      lfsr_q[1]    <= SeedSft;
      lfsr_q[2]    <= SeedTmr;
      for (int i = 0; i < 3; i++) state_q[i] <= StIdle;
    end else begin
      armed_q      <= armed_d;
      stopped_q    <= stopped_d;
      tohost_cnt_q <= tohost_cnt_d;
      irq_q        <= irq_d;
      cnt_q        <= cnt_d;
      inj_cnt_q    <= inj_cnt_d;
      lfsr_q       <= lfsr_d;
      for (int i = 0; i < 3; i++) state_q[i] <= state_d[i];
    end
  end

  assign ext_irq     = irq_q[0];
  assign sft_irq     = irq_q[1];
  assign tmr_irq     = irq_q[2];
  assign irq_quiet   = ~|irq_q;
  assign armed       = armed_q;
  assign stopped     = stopped_q;
  assign tohost_cnt  = tohost_cnt_q;
  assign ext_inj_cnt = inj_cnt_q[0];
  assign sft_inj_cnt = inj_cnt_q[1];
  assign tmr_inj_cnt = inj_cnt_q[2];

endmodule

// File: tb/tb_e203_tb_irq_injector.sv
// Directed bench for e203_tb_irq_injector: small gap width, low stop threshold, zero sft seed.
module tb_e203_tb_irq_injector;

  localparam logic [31:0] PC_ARM     = 32'h8000015C;
  localparam logic [31:0] PC_TOHOST  = 32'h80000086;
  localparam logic [31:0] PC_EXT_HDL = 32'h800000A6;
  localparam logic [31:0] PC_SFT_HDL = 32'h800000BE;
  localparam logic [31:0] PC_TMR_HDL = 32'h800000D6;
  localparam logic [31:0] PC_OTHER   = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst, enable, cmt_valid;
  logic [31:0] cmt_pc;
  logic        ext_irq, sft_irq, tmr_irq, armed, stopped, irq_quiet;
  logic [31:0] tohost_cnt;
  logic [15:0] ext_inj_cnt, sft_inj_cnt, tmr_inj_cnt;

  int checks   = 0;
  int failures = 0;

  // Seeds give first delays ext=6, sft=2 (zero seed -> 1), tmr=11.
  e203_tb_irq_injector #(
    .MAX_GAP_W (4),
    .STOP_CNT  (2),
    .SEED_EXT  (16'h0005),
    .SEED_SFT  (16'h0000),
    .SEED_TMR  (16'h5A5A)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cmt_valid   (cmt_valid),
    .cmt_pc      (cmt_pc),
    .ext_irq     (ext_irq),
    .sft_irq     (sft_irq),
    .tmr_irq     (tmr_irq),
    .armed       (armed),
    .stopped     (stopped),
    .irq_quiet   (irq_quiet),
    .tohost_cnt  (tohost_cnt),
    .ext_inj_cnt (ext_inj_cnt),
    .sft_inj_cnt (sft_inj_cnt),
    .tmr_inj_cnt (tmr_inj_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset(input logic en);
    rst = 1'b1; enable = en; cmt_valid = 1'b0; cmt_pc = PC_OTHER;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++; if ({ext_irq, sft_irq, tmr_irq} !== 3'b000) begin
      failures++; $display("FAIL reset_irqs: got %b want 000", {ext_irq, sft_irq, tmr_irq}); end
    checks++; if (armed !== 1'b0 || stopped !== 1'b0) begin
      failures++; $display("FAIL reset_flags: armed=%b stopped=%b want 0 0", armed, stopped); end
    checks++; if (irq_quiet !== 1'b1) begin
      failures++; $display("FAIL reset_quiet: got %b want 1", irq_quiet); end
    checks++; if (tohost_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_tohost: got %0d want 0", tohost_cnt); end
    checks++; if ({ext_inj_cnt, sft_inj_cnt, tmr_inj_cnt} !== 48'd0) begin
      failures++; $display("FAIL reset_inj: got %0d %0d %0d want 0 0 0",
                           ext_inj_cnt, sft_inj_cnt, tmr_inj_cnt); end
  endtask

  // Called mid-cycle right after reset release; arming commit lands on edge 0.
  task automatic test_arm_delay(input string tag);
    logic [2:0] exp;
    enable = 1'b1; cmt_valid = 1'b1; cmt_pc = PC_ARM;
    step();
    cmt_valid = 1'b0; cmt_pc = PC_OTHER;
    checks++; if (armed !== 1'b1) begin
      failures++; $display("FAIL %s_armed: got %b want 1", tag, armed); end
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = {(k >= 6), (k >= 2), (k >= 11)};
      checks++; if ({ext_irq, sft_irq, tmr_irq} !== exp) begin
        failures++; $display("FAIL %s_rise_edge%0d: got %b want %b", tag, k,
                             {ext_irq, sft_irq, tmr_irq}, exp); end
    end
  endtask

  // Continues at edge 12 with all three lines high.
  task automatic test_handler();
    cmt_valid = 1'b1; cmt_pc = PC_OTHER;
    step();  // edge 13
    checks++; if (ext_irq !== 1'b1) begin
      failures++; $display("FAIL hdl_other_pc: ext_irq got %b want 1", ext_irq); end
    cmt_valid = 1'b0; cmt_pc = PC_EXT_HDL;
    step();  // edge 14
    checks++; if (ext_irq !== 1'b1) begin
      failures++; $display("FAIL hdl_invalid: ext_irq got %b want 1", ext_irq); end
    cmt_valid = 1'b1;
    step();  // edge 15, lfsr 0xA289 -> next delay 10
    cmt_valid = 1'b0; cmt_pc = PC_OTHER;
    checks++; if (ext_irq !== 1'b0 || ext_inj_cnt !== 16'd1) begin
      failures++; $display("FAIL hdl_drop: ext_irq=%b cnt=%0d want 0 1", ext_irq, ext_inj_cnt); end
    checks++; if (sft_irq !== 1'b1 || tmr_irq !== 1'b1) begin
      failures++; $display("FAIL hdl_others: sft=%b tmr=%b want 1 1", sft_irq, tmr_irq); end
    for (int k = 16; k <= 25; k++) begin
      step();
      checks++; if (ext_irq !== (k >= 25)) begin
        failures++; $display("FAIL hdl_redelay_edge%0d: got %b want %b", k, ext_irq, (k >= 25)); end
    end
  endtask

  task automatic test_enable_gating();
    enable = 1'b0;
    repeat (3) step();
    checks++; if (tmr_irq !== 1'b1 || ext_irq !== 1'b1) begin
      failures++; $display("FAIL gate_hold: tmr=%b ext=%b want 1 1", tmr_irq, ext_irq); end
    cmt_valid = 1'b1; cmt_pc = PC_TMR_HDL;
    step();
    cmt_valid = 1'b0; cmt_pc = PC_OTHER;
    checks++; if (tmr_irq !== 1'b0 || tmr_inj_cnt !== 16'd1) begin
      failures++; $display("FAIL gate_drop: tmr=%b cnt=%0d want 0 1", tmr_irq, tmr_inj_cnt); end
    for (int c = 0; c < 40; c++) begin
      step();
      checks++; if (tmr_irq !== 1'b0) begin
        failures++; $display("FAIL gate_idle_cyc%0d: tmr got %b want 0", c, tmr_irq); break; end
    end
  endtask

  task automatic test_reset_mid();
    bit got = 1'b0;
    enable = 1'b1;
    for (int c = 0; c < 40 && !got; c++) begin
      step();
      if (tmr_irq === 1'b1) got = 1'b1;
    end
    checks++; if (!got) begin
      failures++; $display("FAIL mid_tmr_rearm: tmr_irq got 0 want 1 within 40 cycles"); end
    cmt_valid = 1'b1; cmt_pc = PC_TOHOST;
    step();
    cmt_valid = 1'b0; cmt_pc = PC_OTHER;
    checks++; if ({ext_irq, sft_irq, tmr_irq} !== 3'b111 || tohost_cnt !== 32'd1) begin
      failures++; $display("FAIL mid_pre: irqs=%b tohost=%0d want 111 1",
                           {ext_irq, sft_irq, tmr_irq}, tohost_cnt); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({ext_irq, sft_irq, tmr_irq} !== 3'b000 || irq_quiet !== 1'b1) begin
      failures++; $display("FAIL mid_async_drop: irqs=%b quiet=%b want 000 1",
                           {ext_irq, sft_irq, tmr_irq}, irq_quiet); end
    checks++; if (tohost_cnt !== 32'd0 || ext_inj_cnt !== 16'd0 || tmr_inj_cnt !== 16'd0
                  || armed !== 1'b0) begin
      failures++; $display("FAIL mid_counts: tohost=%0d ext=%0d tmr=%0d armed=%b want 0 0 0 0",
                           tohost_cnt, ext_inj_cnt, tmr_inj_cnt, armed); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_arm_delay("replay");
  endtask

  // Continues at edge 12 of a fresh arm sequence.
  task automatic test_stop();
    cmt_valid = 1'b1; cmt_pc = PC_EXT_HDL;
    step();  // edge 13, ext re-enters WAIT with delay 7
    checks++; if (ext_irq !== 1'b0 || ext_inj_cnt !== 16'd1) begin
      failures++; $display("FAIL stop_ext_drop: ext=%b cnt=%0d want 0 1", ext_irq, ext_inj_cnt); end
    cmt_pc = PC_TOHOST;
    repeat (2) step();
    checks++; if (tohost_cnt !== 32'd2 || stopped !== 1'b0) begin
      failures++; $display("FAIL stop_at_thresh: tohost=%0d stopped=%b want 2 0", tohost_cnt, stopped); end
    step();
    cmt_valid = 1'b0; cmt_pc = PC_OTHER;
    checks++; if (tohost_cnt !== 32'd3 || stopped !== 1'b1) begin
      failures++; $display("FAIL stop_over: tohost=%0d stopped=%b want 3 1", tohost_cnt, stopped); end
    for (int c = 0; c < 40; c++) begin
      step();
      checks++; if (ext_irq !== 1'b0) begin
        failures++; $display("FAIL stop_ext_done_cyc%0d: got %b want 0", c, ext_irq); break; end
    end
    checks++; if (sft_irq !== 1'b1 || tmr_irq !== 1'b1) begin
      failures++; $display("FAIL stop_held: sft=%b tmr=%b want 1 1", sft_irq, tmr_irq); end
    cmt_valid = 1'b1; cmt_pc = PC_SFT_HDL;
    step();
    checks++; if (sft_irq !== 1'b0 || sft_inj_cnt !== 16'd1) begin
      failures++; $display("FAIL stop_sft_drop: sft=%b cnt=%0d want 0 1", sft_irq, sft_inj_cnt); end
    cmt_pc = PC_TMR_HDL;
    step();
    cmt_valid = 1'b0; cmt_pc = PC_OTHER;
    checks++; if (tmr_irq !== 1'b0 || tmr_inj_cnt !== 16'd1) begin
      failures++; $display("FAIL stop_tmr_drop: tmr=%b cnt=%0d want 0 1", tmr_irq, tmr_inj_cnt); end
    for (int c = 0; c < 40; c++) begin
      step();
      checks++; if (irq_quiet !== 1'b1) begin
        failures++; $display("FAIL stop_quiet_cyc%0d: got %b want 1", c, irq_quiet); break; end
    end
  endtask

  task automatic test_enable_prearm();
    do_reset(1'b0);
    cmt_valid = 1'b1; cmt_pc = PC_ARM;
    step();
    cmt_valid = 1'b0; cmt_pc = PC_OTHER;
    checks++; if (armed !== 1'b0) begin
      failures++; $display("FAIL prearm_armed: got %b want 0", armed); end
    enable = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      step();
      checks++; if (irq_quiet !== 1'b1 || armed !== 1'b0) begin
        failures++; $display("FAIL prearm_cyc%0d: quiet=%b armed=%b want 1 0", c, irq_quiet, armed);
        break;
      end
    end
  endtask

  task automatic test_saturation();
    do_reset(1'b0);
    force dut.tohost_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.tohost_cnt_q;
    cmt_valid = 1'b1; cmt_pc = PC_TOHOST;
    step();
    checks++; if (tohost_cnt !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL sat_tohost: got %h want ffffffff", tohost_cnt); end
    step();
    cmt_valid = 1'b0; cmt_pc = PC_OTHER;
    checks++; if (tohost_cnt !== 32'hFFFF_FFFF || stopped !== 1'b1) begin
      failures++; $display("FAIL sat_tohost2: got %h stopped=%b want ffffffff 1", tohost_cnt, stopped); end
  endtask

  initial begin
    test_reset();
    test_arm_delay("arm");
    test_handler();
    test_enable_gating();
    test_reset_mid();
    test_stop();
    test_enable_prearm();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
